// File: rtl/ddr3_ctrl_pkg.sv
// rtl/ddr3_ctrl_pkg.sv - shared types and constants for the DDR3 frame writer
// DROP state exists only when WRITE_FRAME_DROP_EN is defined.
package ddr3_ctrl_pkg;

  localparam int DDR3_BURST_LEN = 4;
  localparam int DDR3_ADDR_W = 26;
  localparam logic [2:0] DDR3_AVL_SIZE = 3'b100;
  localparam int BURST_CNT_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_WAIT_DATA,
    ST_BURST,
    ST_COMMIT
`ifdef WRITE_FRAME_DROP_EN
    ,
    ST_DROP
`endif
  } wr_state_e;

endpackage

// File: rtl/ddr3_buffer_tracker.sv
// rtl/ddr3_buffer_tracker.sv - double-buffer empty flags, clear edge detection and target choice
// Prefers the buffer not written last so the reader always gets the newest complete frame.
module ddr3_buffer_tracker (
  input  logic clk,
  input  logic reset,
  input  logic clear_buffer0,
  input  logic clear_buffer1,
  input  logic commit,
  input  logic commit_idx,
  output logic empty0,
  output logic empty1,
  output logic sel_valid,
  output logic sel_idx
);

  logic clr0_hist_q, clr0_hist_d;
  logic clr1_hist_q, clr1_hist_d;
  logic empty0_q, empty0_d;
  logic empty1_q, empty1_d;
  logic last_idx_q, last_idx_d;
  logic other_empty;
  logic same_empty;

  always_comb begin
    clr0_hist_d = clear_buffer0;
    clr1_hist_d = clear_buffer1;
    empty0_d    = empty0_q;
    empty1_d    = empty1_q;
    last_idx_d  = last_idx_q;
    // A clear on an already-empty buffer just re-sets a 1, so no extra guard is needed.
    if (clear_buffer0 && !clr0_hist_q) empty0_d = 1'b1;
    if (clear_buffer1 && !clr1_hist_q) empty1_d = 1'b1;
    if (commit) begin
      last_idx_d = commit_idx;
      if (commit_idx) empty1_d = 1'b0;
      else            empty0_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr0_hist_q <= 1'b0;
      clr1_hist_q <= 1'b0;
      empty0_q    <= 1'b1;
      empty1_q    <= 1'b1;
      last_idx_q  <= 1'b1;
    end else begin
      clr0_hist_q <= clr0_hist_d;
      clr1_hist_q <= clr1_hist_d;
      empty0_q    <= empty0_d;
      empty1_q    <= empty1_d;
      last_idx_q  <= last_idx_d;
    end
  end

  always_comb begin
    other_empty = last_idx_q ? empty0_q : empty1_q;
    same_empty  = last_idx_q ? empty1_q : empty0_q;
    sel_valid   = other_empty || same_empty;
    sel_idx     = other_empty ? ~last_idx_q : last_idx_q;
  end

  assign empty0 = empty0_q;
  assign empty1 = empty1_q;

endmodule

// File: rtl/write_to_ddr3.sv
// rtl/write_to_ddr3.sv - writes captured frames into DDR3 double buffers as 4-beat Avalon bursts
// Define WRITE_FRAME_DROP_EN to discard frames when both buffers are full instead of stalling.
module write_to_ddr3
  import ddr3_ctrl_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 1280,
  parameter int IMAGE_HEIGHT = 1024,
  parameter int DATA_WIDTH   = 64
) (
  input  logic                    ddr3_clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH:0]     fifo_rdata,
  input  logic [11:0]             fifo_usedw,
  output logic                    fifo_rd,
  input  logic [25:0]             ddr3_buffer0_offset,
  input  logic [25:0]             ddr3_buffer1_offset,
  input  logic                    clear_buffer0,
  input  logic                    clear_buffer1,
  output logic                    ddr3_rd_buffer0_empty,
  output logic                    ddr3_rd_buffer1_empty,
  input  logic                    ddr3_avl_ready,
  output logic                    ddr3_avl_burstbegin,
  output logic                    ddr3_avl_write_req,
  output logic [25:0]             ddr3_avl_addr,
  output logic [2:0]              ddr3_avl_size,
  output logic [DATA_WIDTH-1:0]   ddr3_avl_wdata,
  output logic [DATA_WIDTH/8-1:0] ddr3_avl_be,
  output logic                    frame_error
);

  localparam int FRAME_BURSTS = (IMAGE_WIDTH * IMAGE_HEIGHT) / DDR3_BURST_LEN;
  localparam logic [BURST_CNT_W-1:0] LAST_BURST = BURST_CNT_W'(FRAME_BURSTS - 1);
  localparam logic [1:0] LAST_BEAT = 2'(DDR3_BURST_LEN - 1);

  wr_state_e                state_q, state_d;
  logic [DDR3_ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     write_req_q, write_req_d;
  logic                     burstbegin_q, burstbegin_d;
  logic                     frame_error_q, frame_error_d;
  logic [BURST_CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [1:0]               beat_cnt_q, beat_cnt_d;
  logic                     target_q, target_d;
  logic                     abort_q, abort_d;

  logic                     pop;
  logic                     head_valid;
  logic                     head_sof;
  logic [DATA_WIDTH-1:0]    head_pix;
  logic                     accept;
  logic                     commit;
  logic                     sel_valid;
  logic                     sel_idx;

  assign head_valid = (fifo_usedw != 12'd0);
  assign head_sof   = fifo_rdata[DATA_WIDTH];
  assign head_pix   = fifo_rdata[DATA_WIDTH-1:0];
  assign accept     = write_req_q && ddr3_avl_ready;
  assign commit     = (state_q == ST_COMMIT);

  ddr3_buffer_tracker u_tracker (
    .clk           (ddr3_clk),
    .reset         (reset),
    .clear_buffer0 (clear_buffer0),
    .clear_buffer1 (clear_buffer1),
    .commit        (commit),
    .commit_idx    (target_q),
    .empty0        (ddr3_rd_buffer0_empty),
    .empty1        (ddr3_rd_buffer1_empty),
    .sel_valid     (sel_valid),
    .sel_idx       (sel_idx)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    write_req_d   = write_req_q;
    burstbegin_d  = burstbegin_q;
    frame_error_d = 1'b0;
    burst_cnt_d   = burst_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    target_d      = target_q;
    abort_d       = abort_q;
    pop           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (head_valid) begin
          if (head_sof) state_d = ST_SELECT;
          else          pop = 1'b1;
        end
      end
      ST_SELECT: begin
        if (sel_valid) begin
          target_d    = sel_idx;
          addr_d      = sel_idx ? ddr3_buffer1_offset : ddr3_buffer0_offset;
          burst_cnt_d = '0;
          abort_d     = 1'b0;
          state_d     = ST_WAIT_DATA;
        end
`ifdef WRITE_FRAME_DROP_EN
        else if (head_valid) begin
          // Consume this frame's SOF so DROP can hunt for the next one.
          pop     = 1'b1;
          state_d = ST_DROP;
        end
`endif
      end
      ST_WAIT_DATA: begin
        if (fifo_usedw >= 12'(DDR3_BURST_LEN)) begin
          if (head_sof && (burst_cnt_q != '0)) begin
            // New frame arrived on a burst boundary: abort with nothing in flight.
            frame_error_d = 1'b1;
            state_d       = ST_SELECT;
          end else begin
            pop          = 1'b1;
            wdata_d      = head_pix;
            write_req_d  = 1'b1;
            burstbegin_d = 1'b1;
            beat_cnt_d   = 2'd0;
            state_d      = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        if (accept) begin
          burstbegin_d = 1'b0;
          if (beat_cnt_q == LAST_BEAT) begin
            write_req_d = 1'b0;
            addr_d      = addr_q + DDR3_ADDR_W'(DDR3_BURST_LEN);
            burst_cnt_d = burst_cnt_q + 1'b1;
            if (abort_q) begin
              frame_error_d = 1'b1;
              state_d       = ST_SELECT;
            end else if (burst_cnt_q == LAST_BURST) begin
              state_d = ST_COMMIT;
            end else begin
              state_d = ST_WAIT_DATA;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 2'd1;
            // The SOF word belongs to the next frame; pad the burst with the held beat.
            if (abort_q || head_sof) begin
              abort_d = 1'b1;
            end else begin
              pop     = 1'b1;
              wdata_d = head_pix;
            end
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
`ifdef WRITE_FRAME_DROP_EN
      ST_DROP: begin
        if (head_valid) begin
          if (head_sof) state_d = ST_SELECT;
          else          pop = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ddr3_clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_req_q   <= 1'b0;
      burstbegin_q  <= 1'b0;
      frame_error_q <= 1'b0;
      burst_cnt_q   <= '0;
      beat_cnt_q    <= 2'd0;
      target_q      <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      write_req_q   <= write_req_d;
      burstbegin_q  <= burstbegin_d;
      frame_error_q <= frame_error_d;
      burst_cnt_q   <= burst_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      target_q      <= target_d;
      abort_q       <= abort_d;
    end
  end

  assign fifo_rd             = pop && !reset;
  assign ddr3_avl_burstbegin = burstbegin_q;
  assign ddr3_avl_write_req  = write_req_q;
  assign ddr3_avl_addr       = addr_q;
  assign ddr3_avl_size       = DDR3_AVL_SIZE;
  assign ddr3_avl_wdata      = wdata_q;
  assign ddr3_avl_be         = '1;
  assign frame_error         = frame_error_q;

endmodule

// File: tb/tb_write_to_ddr3.sv
// tb/tb_write_to_ddr3.sv - directed/random bench for write_to_ddr3 with a show-ahead FIFO and beat scoreboard
// Frame-3 expectations follow WRITE_FRAME_DROP_EN when defined.
module tb_write_to_ddr3;

  localparam int W = 8;
  localparam int H = 2;
  localparam int DW = 64;
  localparam int NB = W * H;
  localparam logic [25:0] OFF0 = 26'h100;
  localparam logic [25:0] OFF1 = 26'h200;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [DW:0]     fifo_rdata;
  logic [11:0]     fifo_usedw;
  logic            fifo_rd;
  logic [25:0]     off0 = OFF0;
  logic [25:0]     off1 = OFF1;
  logic            clear_buffer0 = 1'b0;
  logic            clear_buffer1 = 1'b0;
  logic            empty0, empty1;
  logic            ready = 1'b1;
  logic            bb, wr, ferr;
  logic [25:0]     addr;
  logic [2:0]      size;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] be;

  write_to_ddr3 #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(DW)) dut (
    .ddr3_clk(clk), .reset(reset), .fifo_rdata(fifo_rdata), .fifo_usedw(fifo_usedw),
    .fifo_rd(fifo_rd), .ddr3_buffer0_offset(off0), .ddr3_buffer1_offset(off1),
    .clear_buffer0(clear_buffer0), .clear_buffer1(clear_buffer1),
    .ddr3_rd_buffer0_empty(empty0), .ddr3_rd_buffer1_empty(empty1),
    .ddr3_avl_ready(ready), .ddr3_avl_burstbegin(bb), .ddr3_avl_write_req(wr),
    .ddr3_avl_addr(addr), .ddr3_avl_size(size), .ddr3_avl_wdata(wdata),
    .ddr3_avl_be(be), .frame_error(ferr)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO: main process writes words/wr_idx, monitor owns rd_idx.
  logic [DW:0] words [0:511];
  int wr_idx = 0;
  int rd_idx = 0;
  assign fifo_rdata = words[rd_idx % 512];
  assign fifo_usedw = 12'(wr_idx - rd_idx);

  logic [90:0] beats [0:511];
  int n_beats = 0;
  int beat_base = 0;
  int cyc = 0;
  int pops = 0;
  int ferr_cnt = 0;
  int e0_rises = 0;
  int e0_fall_edge = -1;
  int last_acc_edge = -1;
  logic e0_prev = 1'b1;
  logic rd_s;

  always begin
    @(negedge clk);
    #4;
    rd_s = fifo_rd;
    if (wr && ready) begin
      beats[n_beats % 512] = {bb, addr, wdata};
      n_beats++;
      last_acc_edge = cyc + 1;
    end
    if (e0_prev && !empty0) e0_fall_edge = cyc;
    if (!e0_prev && empty0) e0_rises++;
    e0_prev = empty0;
    if (ferr) ferr_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_s && (rd_idx != wr_idx)) begin
      rd_idx++;
      pops++;
    end
  end

  typedef struct {
    logic [90:0] v;
    logic [90:0] m;
  } exp_t;
  exp_t exp_q[$];

  int n_assert = 0;
  int n_fail = 0;
  bit rnd_ready = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rnd_ready) ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_word(input logic sof, input logic [DW-1:0] pix);
    words[wr_idx % 512] = {sof, pix};
    wr_idx++;
  endtask

  task automatic add_exp(input logic b, input logic [25:0] a, input logic [DW-1:0] d, input bit data_known);
    exp_t e;
    e.v = {b, a, d};
    e.m = data_known ? {91{1'b1}} : {1'b1, {26{1'b1}}, {DW{1'b0}}};
    exp_q.push_back(e);
  endtask

  // Reference: frame beat i lands at base + 4*(i/4), burstbegin on i%4==0.
  task automatic push_frame(input logic [25:0] base, input bit expect_write);
    logic [DW-1:0] pix;
    for (int i = 0; i < NB; i++) begin
      pix = {$urandom, $urandom};
      push_word(i == 0, pix);
      if (expect_write) add_exp((i % 4) == 0, base + 26'(4 * (i / 4)), pix, 1'b1);
    end
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while ((n_beats - beat_base) < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, (n_beats - beat_base) >= n, 1);
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_count"}, n_beats - beat_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < (n_beats - beat_base); i++)
      chk($sformatf("%s_beat%0d", tag, i), beats[(beat_base + i) % 512] & exp_q[i].m,
          exp_q[i].v & exp_q[i].m);
    beat_base = n_beats;
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] hold_a;
    logic [DW-1:0] hold_d;
    logic [DW-1:0] pix;
    int p0, r0, f0, k;

    repeat (3) @(negedge clk);
    chk("rst_write_req", wr, 0);
    chk("rst_burstbegin", bb, 0);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_frame_error", ferr, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_empty0", empty0, 1);
    chk("rst_empty1", empty1, 1);
    chk("avl_size", size, 3'b100);
    chk("avl_be", be, 8'hff);
    reset = 1'b0;

    // Frame 1: junk words ahead of SOF, ready always high, goes to buffer 0.
    push_word(1'b0, {$urandom, $urandom});
    push_word(1'b0, {$urandom, $urandom});
    push_frame(OFF0, 1'b1);
    wait_beats(NB, 200, "t1_timeout");
    idle(4);
    check_beats("t1");
    chk("t1_empty0_fall_delay", e0_fall_edge - last_acc_edge, 1);
    chk("t1_empty0", empty0, 0);
    chk("t1_empty1", empty1, 1);
    chk("t1_pops", pops, NB + 2);
    chk("t1_fifo_drained", wr_idx - rd_idx, 0);

    // Frame 2: 3-cycle ready stall mid-burst, then random ready; buffer 1.
    push_frame(OFF1, 1'b1);
    k = 0;
    while (!(wr && !bb) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t2_reach_midburst", wr && !bb, 1);
    hold_a = addr;
    hold_d = wdata;
    p0 = pops;
    ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_stall_req", wr, 1);
      chk("t2_stall_addr", addr, hold_a);
      chk("t2_stall_wdata", wdata, hold_d);
      chk("t2_stall_fifo_rd", fifo_rd, 0);
    end
    chk("t2_stall_no_pop", pops, p0);
    ready = 1'b1;
    rnd_ready = 1'b1;
    wait_beats(NB, 400, "t2_timeout");
    rnd_ready = 1'b0;
    ready = 1'b1;
    idle(4);
    check_beats("t2");
    chk("t2_empty0", empty0, 0);
    chk("t2_empty1", empty1, 0);

    // Frame 3 with both buffers full.
`ifdef WRITE_FRAME_DROP_EN
    p0 = pops;
    push_frame(OFF0, 1'b0);
    idle(40);
    chk("t3_dropped_pops", pops - p0, NB);
    chk("t3_no_write", n_beats - beat_base, 0);
`else
    p0 = pops;
    push_frame(OFF0, 1'b1);
    idle(30);
    chk("t3_stalled_pops", pops, p0);
    chk("t3_no_write", n_beats - beat_base, 0);
`endif
    r0 = e0_rises;
    clear_buffer0 = 1'b1;
    idle(10);
    clear_buffer0 = 1'b0;
    idle(1);
    chk("t3_clr0_single_rise", e0_rises - r0, 1);
`ifdef WRITE_FRAME_DROP_EN
    push_frame(OFF0, 1'b1);
`endif
    wait_beats(NB, 300, "t3_timeout");
    idle(4);
    check_beats("t3");
    chk("t3_empty0", empty0, 0);

    // Clear edges: one on a full buffer, a repeat on an already-empty one.
    r0 = e0_rises;
    clear_buffer0 = 1'b1; idle(1); clear_buffer0 = 1'b0; idle(2);
    chk("t4_clr0_rise", e0_rises - r0, 1);
    chk("t4_empty0_set", empty0, 1);
    clear_buffer0 = 1'b1; idle(1); clear_buffer0 = 1'b0; idle(2);
    chk("t4_clr0_noop_rises", e0_rises - r0, 1);
    chk("t4_clr0_noop_empty0", empty0, 1);
    clear_buffer1 = 1'b1; idle(1); clear_buffer1 = 1'b0; idle(2);
    chk("t4_empty1_set", empty1, 1);

    // Mid-frame SOF at beat 6, last committed = 0 so buffer 1 is targeted twice.
    f0 = ferr_cnt;
    for (int i = 0; i < 6; i++) begin
      pix = {$urandom, $urandom};
      push_word(i == 0, pix);
      add_exp((i % 4) == 0, OFF1 + 26'(4 * (i / 4)), pix, 1'b1);
    end
    add_exp(1'b0, OFF1 + 26'd4, '0, 1'b0);
    add_exp(1'b0, OFF1 + 26'd4, '0, 1'b0);
    push_frame(OFF1, 1'b1);
    rnd_ready = 1'b1;
    wait_beats(8, 200, "t5_abort_timeout");
    idle(2);
    chk("t5_frame_error_once", ferr_cnt - f0, 1);
    chk("t5_empty1_kept", empty1, 1);
    wait_beats(8 + NB, 500, "t5_timeout");
    rnd_ready = 1'b0;
    ready = 1'b1;
    idle(4);
    check_beats("t5");
    chk("t5_frame_error_total", ferr_cnt - f0, 1);
    chk("t5_empty1", empty1, 0);
    chk("t5_empty0", empty0, 1);

    // Reset during burst 2 of a frame heading for buffer 0.
    push_frame(OFF0, 1'b0);
    k = 0;
    while (!((n_beats - beat_base) >= 5 && wr) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t6_reach_burst2", (n_beats - beat_base) >= 5 && wr, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_write_req", wr, 0);
    chk("t6_rst_burstbegin", bb, 0);
    chk("t6_rst_addr", addr, 0);
    chk("t6_rst_wdata", wdata, 0);
    chk("t6_rst_fifo_rd", fifo_rd, 0);
    chk("t6_rst_empty1", empty1, 1);
    reset = 1'b0;
    k = 0;
    while (wr_idx != rd_idx && k < 100) begin
      tick();
      k++;
    end
    chk("t6_partial_drained", wr_idx - rd_idx, 0);
    idle(2);
    beat_base = n_beats;
    exp_q.delete();
    push_frame(OFF0, 1'b1);
    wait_beats(NB, 200, "t6_timeout");
    idle(4);
    check_beats("t6");
    chk("t6_empty0", empty0, 0);
    chk("t6_empty1", empty1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
